// File: rtl/dxm_interrupt_svc.sv
// Interrupt servicing engine: snapshots pending unmasked status bits and dispatches
// them lowest-index first over a req/ack handshake, clearing each source when done.
module dxm_interrupt_svc #(
    parameter int VEC_W    = 8,
    parameter int ID_W     = 3,
    parameter int TO_LIMIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             int_req,
    input  logic [VEC_W-1:0] status,
    input  logic [VEC_W-1:0] mask,
    output logic             clr_status_1p,
    output logic [VEC_W-1:0] clr_vec,
    output logic             svc_req,
    output logic [ID_W-1:0]  svc_id,
    input  logic             svc_ack,
    output logic             svc_timeout,
    output logic [7:0]       err_cnt,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_SNAP, S_WAIT_ACK, S_CLEAR, S_SETTLE1, S_SETTLE2
    } state_t;

    state_t           state_q, state_d;
    logic [VEC_W-1:0] pend_q, pend_d;
    logic [7:0]       timer_q, timer_d;
    logic             to_flag_q, to_flag_d;
    logic [ID_W-1:0]  svc_id_q, svc_id_d;
    logic [7:0]       err_q, err_d;

    logic [VEC_W-1:0] snap_vec;
    logic [VEC_W-1:0] sel_vec;
    logic [VEC_W-1:0] rem_vec;

    function automatic logic [ID_W-1:0] lowest_idx(input logic [VEC_W-1:0] v);
        lowest_idx = '0;
        for (int i = VEC_W - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = ID_W'(i);
        end
    endfunction

    assign snap_vec = status & ~mask;
    assign sel_vec  = VEC_W'(1) << svc_id_q;
    assign rem_vec  = pend_q & ~sel_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pend_q    <= '0;
            timer_q   <= '0;
            to_flag_q <= 1'b0;
            svc_id_q  <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            timer_q   <= timer_d;
            to_flag_q <= to_flag_d;
            svc_id_q  <= svc_id_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        timer_d   = timer_q;
        to_flag_d = to_flag_q;
        svc_id_d  = svc_id_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (int_req) state_d = S_SNAP;
            end
            S_SNAP: begin
                pend_d = snap_vec;
                if (snap_vec == '0) begin
                    state_d = S_IDLE;
                end else begin
                    svc_id_d = lowest_idx(snap_vec);
                    timer_d  = '0;
                    state_d  = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                timer_d = timer_q + 8'd1;
                // Ack takes priority over a timeout reached in the same cycle.
                if (svc_ack) begin
                    to_flag_d = 1'b0;
                    state_d   = S_CLEAR;
                end else if (timer_q == 8'(TO_LIMIT)) begin
                    to_flag_d = 1'b1;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (to_flag_q && err_q != 8'hFF) err_d = err_q + 8'd1;
                pend_d = rem_vec;
                if (rem_vec != '0) begin
                    svc_id_d = lowest_idx(rem_vec);
                    timer_d  = '0;
                    state_d  = S_WAIT_ACK;
                end else begin
                    state_d = S_SETTLE1;
                end
            end
            // Two settle cycles let the status block's int_req fall before re-sampling.
            S_SETTLE1: state_d = S_SETTLE2;
            S_SETTLE2: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign svc_req       = (state_q == S_WAIT_ACK);
    assign clr_status_1p = (state_q == S_CLEAR);
    assign clr_vec       = clr_status_1p ? sel_vec : '0;
    assign svc_timeout   = clr_status_1p & to_flag_q;
    assign svc_id        = svc_id_q;
    assign err_cnt       = err_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_dxm_interrupt_svc.sv
// Directed table-driven bench for dxm_interrupt_svc with hand-written sequences for
// reset, ack-outside-handshake and error counter saturation.
module tb_dxm_interrupt_svc;

    localparam int NOACK = -1;
    localparam int TO    = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       int_req;
    logic [7:0] status;
    logic [7:0] mask;
    logic       clr_status_1p;
    logic [7:0] clr_vec;
    logic       svc_req;
    logic [2:0] svc_id;
    logic       svc_ack;
    logic       svc_timeout;
    logic [7:0] err_cnt;
    logic       busy;

    dxm_interrupt_svc #(.VEC_W(8), .ID_W(3), .TO_LIMIT(TO)) dut (
        .clk(clk), .rst(rst), .int_req(int_req), .status(status), .mask(mask),
        .clr_status_1p(clr_status_1p), .clr_vec(clr_vec), .svc_req(svc_req),
        .svc_id(svc_id), .svc_ack(svc_ack), .svc_timeout(svc_timeout),
        .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]      st;
        logic [7:0]      mk;
        int              dly;
        int              inj_cyc;
        logic [7:0]      inj_st;
        logic [7:0]      inj_mk;
        int              n;
        logic [3:0][7:0] clr;
        logic            to;
    } vec_t;

    vec_t vecs[11];
    int   errors = 0;
    int   checks = 0;
    int   cur_row = -1;
    int   exp_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (row %0d): got %0h, expected %0h", nm, cur_row, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_row(input vec_t v);
        int   k, rl, last_clr, exp_len, cyc;
        logic bad, done;
        logic [2:0] id0;
        status  = v.st;
        mask    = v.mk;
        int_req = 1'b1;
        svc_ack = 1'b0;
        tick();
        chk("snap_busy", busy, 1);
        chk("snap_no_req", svc_req, 0);
        int_req  = 1'b0;
        k        = 0;
        rl       = 0;
        last_clr = 0;
        bad      = 1'b0;
        done     = 1'b0;
        id0      = '0;
        exp_len  = (v.dly == NOACK) ? TO + 1 : v.dly + 1;
        for (cyc = 1; cyc <= 200 && !done; cyc++) begin
            if (cyc == v.inj_cyc) begin
                status = status | v.inj_st;
                mask   = mask | v.inj_mk;
                if (v.inj_st != 0) int_req = 1'b1;
            end
            tick();
            if (svc_req) begin
                if (clr_status_1p || clr_vec != 0 || !busy) bad = 1'b1;
                if (rl == 0) begin
                    id0 = svc_id;
                    if (k >= v.n || k > 3) bad = 1'b1;
                    else if ((8'd1 << svc_id) != v.clr[k]) bad = 1'b1;
                    if (!(cyc == 1 || cyc == last_clr + 1)) bad = 1'b1;
                end else if (svc_id != id0) begin
                    bad = 1'b1;
                end
                rl++;
                if (v.dly != NOACK && rl == v.dly + 1) svc_ack = 1'b1;
            end else if (clr_status_1p) begin
                svc_ack = 1'b0;
                if (rl != exp_len) bad = 1'b1;
                if (k < v.n && k <= 3) begin
                    chk("clr_vec", clr_vec, v.clr[k]);
                    chk("svc_timeout", svc_timeout, v.to);
                end else begin
                    bad = 1'b1;
                end
                if (v.to && exp_err < 255) exp_err++;
                k++;
                rl       = 0;
                last_clr = cyc;
            end else begin
                if (clr_vec != 0 || svc_timeout) bad = 1'b1;
                if (!busy) begin
                    done = 1'b1;
                    if (v.n > 0 && cyc - last_clr != 3) bad = 1'b1;
                    if (v.n == 0 && cyc != 1) bad = 1'b1;
                end
            end
        end
        chk("pass_done", done, 1);
        chk("clear_count", k, v.n);
        chk("err_cnt", err_cnt, exp_err);
        chk("sequence_ok", bad, 0);
    endtask

    initial begin
        int   pulses;
        logic bad;

        //        st     mk     dly    inj inj_st inj_mk n  clr                          to
        vecs[0]  = '{8'h08, 8'h00, 3,     0, 8'h00, 8'h00, 1, {8'h00,8'h00,8'h00,8'h08}, 1'b0};
        vecs[1]  = '{8'hA5, 8'h04, 0,     0, 8'h00, 8'h00, 3, {8'h00,8'h80,8'h20,8'h01}, 1'b0};
        vecs[2]  = '{8'h08, 8'h00, NOACK, 0, 8'h00, 8'h00, 1, {8'h00,8'h00,8'h00,8'h08}, 1'b1};
        vecs[3]  = '{8'h08, 8'h00, 15,    0, 8'h00, 8'h00, 1, {8'h00,8'h00,8'h00,8'h08}, 1'b0};
        vecs[4]  = '{8'h10, 8'h10, 0,     0, 8'h00, 8'h00, 0, {8'h00,8'h00,8'h00,8'h00}, 1'b0};
        vecs[5]  = '{8'h00, 8'h00, 0,     0, 8'h00, 8'h00, 0, {8'h00,8'h00,8'h00,8'h00}, 1'b0};
        vecs[6]  = '{8'h0F, 8'h00, 0,     0, 8'h00, 8'h00, 4, {8'h08,8'h04,8'h02,8'h01}, 1'b0};
        vecs[7]  = '{8'h01, 8'h00, 2,     2, 8'h02, 8'h00, 1, {8'h00,8'h00,8'h00,8'h01}, 1'b0};
        vecs[8]  = '{8'h02, 8'h00, 1,     0, 8'h00, 8'h00, 1, {8'h00,8'h00,8'h00,8'h02}, 1'b0};
        vecs[9]  = '{8'h06, 8'h00, 1,     2, 8'h00, 8'h04, 2, {8'h00,8'h00,8'h04,8'h02}, 1'b0};
        vecs[10] = '{8'h81, 8'h00, NOACK, 0, 8'h00, 8'h00, 2, {8'h00,8'h00,8'h80,8'h01}, 1'b1};

        rst     = 1'b1;
        int_req = 1'b0;
        status  = '0;
        mask    = '0;
        svc_ack = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_svc_req", svc_req, 0);
        chk("rst_clr", {clr_status_1p, clr_vec, svc_timeout}, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_svc_id", svc_id, 0);
        rst = 1'b0;

        // Ack while idle must not start anything.
        bad     = 1'b0;
        svc_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy || svc_req || clr_status_1p || clr_vec != 0) bad = 1'b1;
        end
        svc_ack = 1'b0;
        chk("idle_ack_ignored", bad, 0);

        for (int r = 0; r < 11; r++) begin
            cur_row = r;
            run_row(vecs[r]);
        end
        cur_row = -1;

        // Reset in the middle of a handshake.
        status  = 8'h10;
        mask    = 8'h00;
        int_req = 1'b1;
        tick();
        int_req = 1'b0;
        tick();
        tick();
        chk("pre_rst_req", svc_req, 1);
        chk("pre_rst_err", err_cnt, exp_err);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_req", svc_req, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_err", err_cnt, 0);
        chk("async_rst_id", svc_id, 0);
        tick();
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (clr_status_1p || clr_vec != 0 || busy || svc_req) bad = 1'b1;
        end
        chk("no_clear_after_rst", bad, 0);

        // Saturation of the error counter under continuous timeouts.
        status  = 8'hFF;
        mask    = 8'h00;
        int_req = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 6000 && pulses < 260; i++) begin
            tick();
            if (svc_timeout) pulses++;
        end
        int_req = 1'b0;
        chk("timeout_pulses", pulses, 260);
        tick();
        chk("err_saturated", err_cnt, 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
